// File: rtl/det_event_logger_if.sv
// Record stream from the event logger: a valid/ready handshake carrying a
// run length and the sequence number of the event that started that run.
interface det_event_logger_if #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
);
  logic             rec_valid;
  logic             rec_ready;
  logic [LEN_W-1:0] rec_len;
  logic [CNT_W-1:0] rec_seq;

  modport master (output rec_valid, rec_len, rec_seq, input rec_ready);
  modport slave  (input rec_valid, rec_len, rec_seq, output rec_ready);
endinterface

// File: rtl/det_event_logger.sv
// Counts detections from a serial pattern detector, measures the length of
// each detection run and queues {len, seq} records in a small FWFT FIFO.
module det_event_logger #(
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 8,
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 det_in,
  input  logic                 clr,
  output logic                 event_pulse,
  output logic [CNT_W-1:0]     event_count,
  output logic                 overflow,
  det_event_logger_if.master   rec_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] run_len, run_len_nxt;
  logic [HW-1:0]    hold_cnt, hold_cnt_nxt;
  logic             accept;
  logic             push;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt    = state;
    run_len_nxt  = run_len;
    hold_cnt_nxt = hold_cnt;
    accept       = 1'b0;
    push         = 1'b0;
    unique case (state)
      IDLE: begin
        if (det_in) begin
          state_nxt   = RUN;
          run_len_nxt = LEN_W'(1);
          accept      = 1'b1;
        end
      end
      RUN: begin
        if (det_in) begin
          if (run_len != '1) run_len_nxt = run_len + 1'b1;
        end else begin
          push = 1'b1;
          if (HOLDOFF == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt    = HOLD;
            hold_cnt_nxt = HW'(HOLDOFF);
          end
        end
      end
      HOLD: begin
        // det_in is deliberately ignored while the holdoff drains
        hold_cnt_nxt = hold_cnt - 1'b1;
        if (hold_cnt == HW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Record FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [LEN_W-1:0] mem_len [DEPTH];
  logic [CNT_W-1:0] mem_seq [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rec_if.rec_valid && rec_if.rec_ready;
  assign do_push = push && (!full || pop) && !clr;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      run_len     <= '0;
      hold_cnt    <= '0;
      event_pulse <= 1'b0;
      event_count <= '0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_nxt;
      run_len     <= run_len_nxt;
      hold_cnt    <= hold_cnt_nxt;
      event_pulse <= accept;
      if (clr) begin
        event_count <= '0;
        overflow    <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        if (accept)                 event_count <= event_count + 1'b1;
        if (pop)                    rd_ptr      <= rd_ptr + 1'b1;
        if (do_push)                wr_ptr      <= wr_ptr + 1'b1;
        if (push && full && !pop)   overflow    <= 1'b1;
      end
    end
  end

  // NOTE: the record storage has no reset; empty-gating on the outputs hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_len[wr_ptr[AW-1:0]] <= run_len;
      mem_seq[wr_ptr[AW-1:0]] <= event_count;
    end
  end

  assign rec_if.rec_valid = !empty;
  assign rec_if.rec_len   = empty ? '0 : mem_len[rd_ptr[AW-1:0]];
  assign rec_if.rec_seq   = empty ? '0 : mem_seq[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_det_event_logger.sv
// Self-checking bench for det_event_logger: a directed vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_det_event_logger;

  localparam int LEN_W   = 8;
  localparam int CNT_W   = 8;
  localparam int DEPTH   = 4;
  localparam int HOLDOFF = 3;
  localparam int LEN_MAX = (1 << LEN_W) - 1;
  localparam int CNT_MOD = 1 << CNT_W;

  logic clk = 1'b0;
  logic reset;
  logic det_in, clr;
  logic event_pulse, overflow;
  logic [CNT_W-1:0] event_count;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  det_event_logger_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) rif ();

  det_event_logger #(.LEN_W(LEN_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .det_in      (det_in),
    .clr         (clr),
    .event_pulse (event_pulse),
    .event_count (event_count),
    .overflow    (overflow),
    .rec_if      (rif.master)
  );

  always #5 clk = ~clk;

  // Reference model: run/holdoff bookkeeping with plain integers, records in a queue.
  typedef struct { int len; int seq; } rec_t;
  rec_t m_q[$];
  bit   m_in_run, m_pulse, m_ovf;
  int   m_len, m_hold, m_count;

  function automatic void model_reset();
    m_q.delete();
    m_in_run = 0; m_pulse = 0; m_ovf = 0;
    m_len = 0; m_hold = 0; m_count = 0;
  endfunction

  function automatic void model_step(bit d, bit c, bit r);
    bit   accept = 0;
    bit   push   = 0;
    bit   pop;
    rec_t rec;
    pop = (m_q.size() > 0) && r;
    if (m_hold > 0) begin
      m_hold--;
    end else if (m_in_run) begin
      if (d) m_len = (m_len < LEN_MAX) ? m_len + 1 : LEN_MAX;
      else begin
        push = 1; rec.len = m_len; rec.seq = m_count;
        m_in_run = 0; m_hold = HOLDOFF;
      end
    end else if (d) begin
      accept = 1; m_in_run = 1; m_len = 1;
    end
    m_pulse = accept;
    if (c) begin
      m_q.delete(); m_count = 0; m_ovf = 0;
    end else begin
      if (accept) m_count = (m_count + 1) % CNT_MOD;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(rec);
        else m_ovf = 1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("rnd_pulse", 32'(event_pulse), 32'(m_pulse));
    check("rnd_count", 32'(event_count), 32'(m_count));
    check("rnd_ovf",   32'(overflow),    32'(m_ovf));
    check("rnd_valid", 32'(rif.rec_valid), 32'(m_q.size() > 0));
    check("rnd_len",   32'(rif.rec_len), (m_q.size() > 0) ? 32'(m_q[0].len) : 32'd0);
    check("rnd_seq",   32'(rif.rec_seq), (m_q.size() > 0) ? 32'(m_q[0].seq) : 32'd0);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick(input bit d, input bit c, input bit r);
    det_in = d; clr = c; rif.rec_ready = r;
    @(posedge clk);
    #1;
    model_step(d, c, r);
    if (cmp_en) check_model();
  endtask

  task automatic do_reset();
    reset = 1'b0; det_in = 1'b0; clr = 1'b0; rif.rec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pulse", 32'(event_pulse), 0);
    check("rst_count", 32'(event_count), 0);
    check("rst_valid", 32'(rif.rec_valid), 0);
    check("rst_len",   32'(rif.rec_len), 0);
    check("rst_seq",   32'(rif.rec_seq), 0);
    check("rst_ovf",   32'(overflow), 0);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic short_run();
    tick(1, 0, 0); tick(1, 0, 0);
    repeat (4) tick(0, 0, 0);
  endtask

  typedef struct {
    bit det; bit clr; bit rdy;
    bit pulse; int count; bit valid; int len; int seq; bit ovf;
  } vec_t;

  vec_t vecs[9];
  bit   pat[14];

  initial begin
    // Single 5-cycle run drained immediately.
    vecs[0] = '{1, 0, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 1; i < 5; i++) vecs[i] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
    vecs[5] = '{0, 0, 1, 0, 1, 1, 5, 1, 0};
    for (int i = 6; i < 9; i++) vecs[i] = '{0, 0, 1, 0, 1, 0, 0, 0, 0};
    pat = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick(vecs[i].det, vecs[i].clr, vecs[i].rdy);
      check($sformatf("vec%0d_pulse", i), 32'(event_pulse), 32'(vecs[i].pulse));
      check($sformatf("vec%0d_count", i), 32'(event_count), 32'(vecs[i].count));
      check($sformatf("vec%0d_valid", i), 32'(rif.rec_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d_len", i),   32'(rif.rec_len), 32'(vecs[i].len));
      check($sformatf("vec%0d_seq", i),   32'(rif.rec_seq), 32'(vecs[i].seq));
      check($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(vecs[i].ovf));
    end

    // Holdoff swallows part of the second run.
    do_reset();
    for (int i = 0; i < 14; i++) tick(pat[i], 0, 0);
    check("hold_len1", 32'(rif.rec_len), 3);
    check("hold_seq1", 32'(rif.rec_seq), 1);
    tick(0, 0, 1);
    check("hold_len2", 32'(rif.rec_len), 2);
    check("hold_seq2", 32'(rif.rec_seq), 2);

    // Overflow with consumer stalled, then ordered drain.
    do_reset();
    for (int k = 0; k < 5; k++) short_run();
    check("ovf_valid", 32'(rif.rec_valid), 1);
    check("ovf_flag",  32'(overflow), 1);
    check("ovf_count", 32'(event_count), 5);
    for (int k = 1; k <= DEPTH; k++) begin
      check($sformatf("drain%0d_seq", k), 32'(rif.rec_seq), 32'(k));
      check($sformatf("drain%0d_len", k), 32'(rif.rec_len), 2);
      tick(0, 0, 1);
    end
    check("drain_empty", 32'(rif.rec_valid), 0);

    // Clear with records queued and overflow still sticky.
    short_run(); short_run();
    check("pre_clr_valid", 32'(rif.rec_valid), 1);
    tick(0, 1, 0);
    check("clr_valid", 32'(rif.rec_valid), 0);
    check("clr_count", 32'(event_count), 0);
    check("clr_ovf",   32'(overflow), 0);
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
    check("post_clr_seq", 32'(rif.rec_seq), 1);

    // Run-length saturation.
    do_reset();
    repeat (300) tick(1, 0, 0);
    tick(0, 0, 0);
    check("sat_valid", 32'(rif.rec_valid), 1);
    check("sat_len",   32'(rif.rec_len), LEN_MAX);
    check("sat_seq",   32'(rif.rec_seq), 1);

    // Asynchronous reset in the middle of a run.
    do_reset();
    repeat (3) tick(1, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("arst_count", 32'(event_count), 0);
    check("arst_pulse", 32'(event_pulse), 0);
    check("arst_valid", 32'(rif.rec_valid), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick(1, 0, 0);
    check("arst_rel_pulse", 32'(event_pulse), 1);
    check("arst_rel_count", 32'(event_count), 1);
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
    check("arst_rec_len", 32'(rif.rec_len), 3);
    check("arst_rec_seq", 32'(rif.rec_seq), 1);

    // Randomized traffic against the reference model.
    do_reset();
    cmp_en = 1'b1;
    begin
      bit d = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 3) == 0) d = ~d;
        tick(d, $urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0);
      end
    end
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/det_event_logger.md
DET_EVENT_LOGGER -- requirements
Module: det_event_logger

Interface
REQ-001 Parameter LEN_W, 8, width of run-length field.
REQ-002 Parameter CNT_W, 8, width of event counter and sequence number.
REQ-003 Parameter DEPTH, 4, record FIFO depth (power of two, >=2).
REQ-004 Parameter HOLDOFF, 3, cycles det_in is ignored after a run ends (0 allowed).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 det_in  input  1  level detection flag from the upstream serial pattern detector.
REQ-008 clr  input  1  synchronous clear of counter, overflow flag and FIFO.
REQ-009 event_pulse  output  1  one-cycle strobe per accepted detection.
REQ-010 event_count  output  CNT_W  number of accepted detections, modulo 2^CNT_W.
REQ-011 rec_valid  output  1  FIFO head record available.
REQ-012 rec_ready  input  1  consumer accepts head record when rec_valid=1.
REQ-013 rec_len  output  LEN_W  head record run length, cycles.
REQ-014 rec_seq  output  CNT_W  head record sequence number.
REQ-015 overflow  output  1  sticky: a record was dropped because FIFO was full.

Function
REQ-016 FSM states IDLE, RUN, HOLD SHALL be implemented; reset state IDLE.
REQ-017 IDLE, det_in=1 sampled: next state RUN, run length <=1, event_count increments, event_pulse=1 for the following cycle only.
REQ-018 IDLE, det_in=0: stay IDLE.
REQ-019 RUN, det_in=1: run length increments, saturating at 2^LEN_W-1.
REQ-020 RUN, det_in=0: push record {len, seq=current event_count}; next state HOLD with holdoff counter=HOLDOFF, or IDLE directly if HOLDOFF=0.
REQ-021 HOLD: det_in ignored; counter decrements each edge; on transition 1->0 next state IDLE (exactly HOLDOFF edges in HOLD).
REQ-022 event_count wraps from 2^CNT_W-1 to 0; seq carries the wrapped value.
REQ-023 FIFO first-word-fall-through: a record pushed at edge m is visible on rec_len/rec_seq with rec_valid=1 after edge m when FIFO was empty.
REQ-024 Pop occurs at an edge where rec_valid=1 and rec_ready=1; records leave in push order.
REQ-025 Push when full and no simultaneous pop: record dropped, overflow set to 1; push with simultaneous pop when full: both performed, no drop.
REQ-026 rec_len/rec_seq SHALL hold stable while rec_valid=1 and rec_ready=0.
REQ-027 clr=1: at next edge event_count=0, overflow=0, FIFO empty; FSM state and run length unaffected; a push in the same cycle as clr is discarded.
REQ-028 clr has priority over push, pop and counter increment in the same cycle.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, event_pulse=0, event_count=0, rec_valid=0, overflow=0, run length=0, holdoff=0, FIFO pointers=0.
REQ-030 A run in progress at reset SHALL produce no record; after release with det_in=1, IDLE accepts a new event.
REQ-031 rec_len/rec_seq read 0 while FIFO empty after reset.

Verification (HOLDOFF=3, DEPTH=4, LEN_W=CNT_W=8)
REQ-032 det_in high 5 cycles then low, rec_ready=1 -> one event_pulse, record len=5 seq=1, event_count=1.
REQ-033 det_in 3 high, 2 low, 4 high, low -> records (len=3,seq=1), (len=2,seq=2); second event_pulse two cycles after det_in rises.
REQ-034 rec_ready=0, five 2-cycle runs spaced 6 cycles -> 4 records held, overflow=1, event_count=5; then rec_ready=1 drains seq 1,2,3,4 in order, rec_valid=0 after.
REQ-035 det_in high 300 cycles -> record len=255, seq=1.
REQ-036 reset asserted mid-run with det_in=1, released with det_in=1 -> outputs 0 during reset, event_pulse after release, final record seq=1.
REQ-037 two records queued, overflow=1, clr pulsed -> next cycle rec_valid=0, event_count=0, overflow=0; next event gets seq=1.
